// File: rtl/mac_tx_arb_pkg.sv
// mac_tx_arb_pkg: shared widths, FSM encoding and tuser field offsets for the MAC TX arbiter.
package mac_tx_arb_pkg;

   localparam int LP_DATA_W   = 64;
   localparam int LP_USER_W   = 80;
   localparam int LP_KEEP_W   = 8;

   localparam int LP_LEN_MSB  = 79;
   localparam int LP_MAC_MSB  = 63;
   localparam int LP_TYPE_MSB = 15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

endpackage

// File: rtl/mac_tx_arbiter_rr_grant2.sv
// rr_grant2: combinational two-requester round-robin pick; on a tie the port that did not go last wins.
module rr_grant2 (
   input  logic [1:0] i_req,
   input  logic       i_last_grant,
   output logic [1:0] o_grant
);

   assign o_grant = (&i_req) ? (i_last_grant ? 2'b01 : 2'b10) : i_req;

endmodule

// File: rtl/mac_tx_arbiter.sv
// mac_tx_arbiter: frame-atomic 2:1 AXI-stream arbiter in front of one MAC TX,
// round-robin grant with a fixed idle gap between frames.
module mac_tx_arbiter
   import mac_tx_arb_pkg::*;
#(
   parameter int P_DATA_WIDTH = LP_DATA_W,
   parameter int P_USER_WIDTH = LP_USER_W,
   parameter int P_KEEP_WIDTH = LP_KEEP_W,
   parameter int P_GAP_CYCLES = 2
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [P_DATA_WIDTH-1:0] s0_axis_tdata,
   input  logic [P_USER_WIDTH-1:0] s0_axis_tuser,
   input  logic [P_KEEP_WIDTH-1:0] s0_axis_tkeep,
   input  logic                    s0_axis_tlast,
   input  logic                    s0_axis_tvalid,
   output logic                    s0_axis_tready,
   input  logic [P_DATA_WIDTH-1:0] s1_axis_tdata,
   input  logic [P_USER_WIDTH-1:0] s1_axis_tuser,
   input  logic [P_KEEP_WIDTH-1:0] s1_axis_tkeep,
   input  logic                    s1_axis_tlast,
   input  logic                    s1_axis_tvalid,
   output logic                    s1_axis_tready,
   output logic [P_DATA_WIDTH-1:0] m_axis_tdata,
   output logic [P_USER_WIDTH-1:0] m_axis_tuser,
   output logic [P_KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                    m_axis_tlast,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic [1:0]              o_grant,
   output logic                    o_busy,
   output logic [15:0]             o_frame_cnt0,
   output logic [15:0]             o_frame_cnt1
);

   localparam logic [3:0] LP_GAP_LOAD = 4'(P_GAP_CYCLES - 1);

   state_t      r_state;
   logic [1:0]  r_grant;
   logic        r_last;
   logic [3:0]  r_gap;
   logic [15:0] r_cnt0;
   logic [15:0] r_cnt1;
   logic [1:0]  w_next_grant;
   logic        w_xfer;
   logic        w_sel;
   logic        w_done;

   rr_grant2 u_rr (
      .i_req        ({s1_axis_tvalid, s0_axis_tvalid}),
      .i_last_grant (r_last),
      .o_grant      (w_next_grant)
   );

   assign w_xfer = r_state == ST_XFER;
   assign w_sel  = r_grant[1];

   // Pure pass-through of the owner; everything is forced to zero outside XFER.
   assign m_axis_tdata   = !w_xfer ? '0 : w_sel ? s1_axis_tdata : s0_axis_tdata;
   assign m_axis_tuser   = !w_xfer ? '0 : w_sel ? s1_axis_tuser : s0_axis_tuser;
   assign m_axis_tkeep   = !w_xfer ? '0 : w_sel ? s1_axis_tkeep : s0_axis_tkeep;
   assign m_axis_tlast   = w_xfer & (w_sel ? s1_axis_tlast : s0_axis_tlast);
   assign m_axis_tvalid  = w_xfer & (w_sel ? s1_axis_tvalid : s0_axis_tvalid);
   assign s0_axis_tready = w_xfer & r_grant[0] & m_axis_tready;
   assign s1_axis_tready = w_xfer & r_grant[1] & m_axis_tready;
   assign w_done         = m_axis_tvalid & m_axis_tready & m_axis_tlast;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_grant <= 2'b00;
         r_last  <= 1'b1;
         r_gap   <= 4'd0;
         r_cnt0  <= 16'd0;
         r_cnt1  <= 16'd0;
      end else begin
         case (r_state)
            ST_IDLE: if (|w_next_grant) begin
               r_grant <= w_next_grant;
               r_state <= ST_XFER;
            end
            ST_XFER: if (w_done) begin
               r_grant <= 2'b00;
               r_last  <= w_sel;
               r_gap   <= LP_GAP_LOAD;
               r_state <= P_GAP_CYCLES > 0 ? ST_GAP : ST_IDLE;
               if (w_sel) r_cnt1 <= r_cnt1 + 16'd1;
               else r_cnt0 <= r_cnt0 + 16'd1;
            end
            ST_GAP: if (r_gap == 4'd0) r_state <= ST_IDLE;
               else r_gap <= r_gap - 4'd1;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_grant      = r_grant;
   assign o_busy       = r_state != ST_IDLE;
   assign o_frame_cnt0 = r_cnt0;
   assign o_frame_cnt1 = r_cnt1;

endmodule

// File: doc/mac_tx_arbiter.md
Name: mac_tx_arbiter

Overview:
Frame-atomic 2:1 AXI-stream arbiter that shares one TEN_GIG_MAC_TX instance between two requesters, e.g. an ARP engine on port 0 and an IP engine on port 1. It uses round-robin grant and enforces a configurable idle gap between frames. It sits directly upstream of the MAC TX s_axis interface and drives it with the same data/user/keep/last/valid/ready bus.

Parameters:
P_DATA_WIDTH, 64, tdata width.
P_USER_WIDTH, 80, tuser width; layout {len[15:0], mac[47:0], type[15:0]} passed untouched.
P_KEEP_WIDTH, 8, tkeep width (P_DATA_WIDTH/8).
P_GAP_CYCLES, 2, idle cycles forced between frames (0..15; 0 = no gap).

Ports:
i_clk  in  1  single clock (xgmii clock domain)
i_rst  in  1  asynchronous active-high reset
s0_axis_tdata  in  64  port 0 data
s0_axis_tuser  in  80  port 0 user
s0_axis_tkeep  in  8  port 0 keep
s0_axis_tlast  in  1  port 0 last
s0_axis_tvalid  in  1  port 0 valid
s0_axis_tready  out  1  port 0 ready
s1_axis_*  same set as port 0, for port 1
m_axis_tdata  out  64  to MAC TX
m_axis_tuser  out  80  to MAC TX
m_axis_tkeep  out  8  to MAC TX
m_axis_tlast  out  1  to MAC TX
m_axis_tvalid  out  1  to MAC TX
m_axis_tready  in  1  from MAC TX s_axis_tready
o_grant  out  2  one-hot current owner; 00 when none
o_busy  out  1  high in XFER or GAP
o_frame_cnt0  out  16  frames completed from port 0, wraps
o_frame_cnt1  out  16  frames completed from port 1, wraps

Behaviour:
- Reset (async assert, sync release via i_clk edge): state=IDLE, o_grant=00, last_grant=port1 (so port 0 wins the first tie), gap counter=0, frame counters=0, all m_axis_* and s*_tready=0.
- FSM states IDLE, XFER, GAP; state and grant are registered.
- IDLE: sX_tready=0 and m_axis_tvalid=0. If any sX_tvalid, register grant in the same cycle and go to XFER next cycle.
  - Both valid: grant the port != last_grant.
  - Single valid: grant that port.
  - Arbitration latency is 1 cycle; no beat is transferred in IDLE.
- XFER: combinational pass-through of the granted port.
  - m_axis_* = granted s_axis_*.
  - granted sX_tready = m_axis_tready; non-granted tready=0.
  - A beat completes when m_axis_tvalid & m_axis_tready.
  - Grant is held until a completing beat with tlast=1, regardless of the other port's valid.
  - tvalid bubbles from the owner are passed through (m_axis_tvalid=0) and do not release the grant.
- On the completing tlast beat:
  - increment that port's frame counter (16-bit wrap 0xFFFF->0x0000);
  - last_grant=owner;
  - o_grant->00 next cycle;
  - next state GAP if P_GAP_CYCLES>0, else IDLE.
- GAP: all tready=0, m_axis_tvalid=0. Counter loads P_GAP_CYCLES-1 on entry and decrements; at 0 go to IDLE. The GAP dwell is exactly P_GAP_CYCLES cycles.
- Single-beat frame (tvalid&tlast on the first XFER beat) is legal.
- Non-granted inputs are never dropped; they are held by the requester under AXI rules.
- Non-XFER m_axis_tdata/tuser/tkeep/tlast are driven 0.
- Async reset mid-frame aborts the frame immediately. Downstream MAC TX shares i_rst, so no partial-frame recovery is required.
- o_busy = (state != IDLE).

Decomposition:
- Package mac_tx_arb_pkg: width localparams (64/80/8), state encoding (IDLE=2'd0, XFER=2'd1, GAP=2'd2), tuser field offsets (LEN_MSB=79, MAC_MSB=63, TYPE_MSB=15).
- One sub-module, rr_grant2: purely combinational next-grant from {req1,req0,last_grant}. It is reusable for later 3+ port TX sharing.

Test Plan:
1. Port 0 only, 10-beat frame (data 64'h1122334455667788, tuser {16'd10,48'd0,16'h0800}, last keep 8'hFE), m_tready=1 -> beats appear on m_axis starting 1 cycle after tvalid, bit-exact, o_grant=01; o_frame_cnt0=1; 2 GAP cycles before next grant.
2. Both ports assert tvalid in the same cycle after reset, 3-beat frames -> port 0 first, then port 1 after 2 gap cycles; repeat both -> order 0,1,0,1; counters 2/2.
3. Port 1 mid-frame, m_tready toggles 1,0,1,0 and port 0 asserts tvalid -> grant stays 10 until port 1 tlast handshake; no port 0 beat interleaved; beat count and order preserved.
4. Owner drops tvalid for 3 cycles mid-frame -> m_axis_tvalid=0 those cycles, o_grant unchanged, frame resumes intact.
5. P_GAP_CYCLES=0, back-to-back single-beat frames on port 1 only -> one frame transferred every 2 cycles (IDLE+XFER); o_frame_cnt1 preset near wrap by 65537 frames -> reads 1.
6. Assert i_rst asynchronously (between edges) during beat 4 of a 10-beat frame -> all outputs 0 immediately; after release, a fresh port 0 frame is granted and forwarded cleanly.
